// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush and a saturating stall counter.
// Optional 2-entry skid buffer (registered InReady) enabled by defining PIPE_STAGE_SKID_EN.
module pipe_stage_reg #(
  parameter int unsigned          PAYLOAD_W = 279,
  parameter logic [PAYLOAD_W-1:0] RESET_VAL = '0,
  parameter int unsigned          CNT_W     = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Flush,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [PAYLOAD_W-1:0] InData,
  input  logic                 InWe,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [PAYLOAD_W-1:0] OutData,
  output logic                 OutWe,
  output logic [CNT_W-1:0]     StallCnt
);

  logic                 main_valid_q, main_valid_d;
  logic [PAYLOAD_W-1:0] main_data_q,  main_data_d;
  logic                 main_we_q,    main_we_d;
  logic [CNT_W-1:0]     stall_cnt_q,  stall_cnt_d;

  logic in_ready_c;
  logic in_xfer_c;
  logic main_load_c;

`ifdef PIPE_STAGE_SKID_EN
  logic                 skid_valid_q, skid_valid_d;
  logic [PAYLOAD_W-1:0] skid_data_q,  skid_data_d;
  logic                 skid_we_q,    skid_we_d;

  // Registered ready: the stage can always absorb one more entry while the skid is free.
  assign in_ready_c = !skid_valid_q;
`else
  assign in_ready_c = OutReady | !main_valid_q;
`endif

  assign in_xfer_c   = InValid & in_ready_c;
  assign main_load_c = !main_valid_q | OutReady;

  // Next-state for main and skid entries; the stored we is cleared whenever an entry is invalid.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_we_d    = main_we_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_we_d    = skid_we_q;
`endif
    if (Flush) begin
      main_valid_d = 1'b0;
      main_we_d    = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_d = 1'b0;
      skid_we_d    = 1'b0;
`endif
    end else if (main_load_c) begin
`ifdef PIPE_STAGE_SKID_EN
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_we_d    = skid_we_q;
        skid_valid_d = 1'b0;
        skid_we_d    = 1'b0;
      end else
`endif
      if (in_xfer_c) begin
        main_valid_d = 1'b1;
        main_data_d  = InData;
        main_we_d    = InWe;
      end else begin
        main_valid_d = 1'b0;
        main_we_d    = 1'b0;
      end
    end
`ifdef PIPE_STAGE_SKID_EN
    else if (in_xfer_c) begin
      skid_valid_d = 1'b1;
      skid_data_d  = InData;
      skid_we_d    = InWe;
    end
`endif
  end

  // Saturating count of stalled cycles; flush does not touch it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !OutReady && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= RESET_VAL;
      main_we_q    <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_we_q    <= main_we_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= RESET_VAL;
      skid_we_q    <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_we_q    <= skid_we_d;
    end
  end
`endif

  assign InReady  = in_ready_c;
  assign OutValid = main_valid_q;
  assign OutData  = main_data_q;
  assign OutWe    = main_we_q;
  assign StallCnt = stall_cnt_q;

endmodule
